data_axi_bridge: RTL

//  Data-side bus bridge downstream of the EX-stage store/load request formatter.

---
 rtl/data_axi_bridge_pkg.sv | 37 +++
 rtl/data_axi_bridge_axi_wr_chan.sv | 53 +++++
 rtl/data_axi_bridge.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/data_axi_bridge_pkg.sv
// ---------------------------------------------------------------------------
// data_axi_bridge_pkg
// Shared types and helpers for the data-side AXI bridge:
//   bridge_state_t      - top-level transaction FSM states
//   AXI_BURST_INCR      - burst encoding used on both address channels
//   AXI_SIZE_B/H/W      - AXI transfer size encodings (1, 2, 4 bytes)
//   axi_size_from_wen() - store transfer size derived from the byte enables
// ---------------------------------------------------------------------------
package data_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR_AW,
        WR_B,
        DONE
    } bridge_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [2:0] AXI_SIZE_B = 3'd0;
    localparam logic [2:0] AXI_SIZE_H = 3'd1;
    localparam logic [2:0] AXI_SIZE_W = 3'd2;

    // Single-lane enables are byte stores, the two aligned lane pairs are
    // halfword stores, and everything else (full word and the partial-word
    // SWL/SWR patterns) goes out as a full-word transfer with strobes.
    function automatic logic [2:0] axi_size_from_wen(input logic [3:0] wen);
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return AXI_SIZE_B;
            4'b0011, 4'b1100:                   return AXI_SIZE_H;
            default:                            return AXI_SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/data_axi_bridge_axi_wr_chan.sv
// ---------------------------------------------------------------------------
// axi_wr_chan
// Tracks the AW and W handshakes of a single-beat write. Both valids rise
// together when 'active' goes high; each drops on its own handshake.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   active          bridge is in its write-address/data state
//   awready, wready slave ready inputs
//   awvalid, wvalid valid outputs towards the slave
//   both_done       both handshakes complete (including this cycle)
// ---------------------------------------------------------------------------
module axi_wr_chan (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic awready,
    input  logic wready,
    output logic awvalid,
    output logic wvalid,
    output logic both_done
);

    logic aw_done;
    logic w_done;
    logic aw_hs;
    logic w_hs;

    // Each side's valid is withdrawn once that side has handshaken, so a
    // slow AW does not cause a duplicate W beat and vice versa.
    always_comb begin
        awvalid   = active & ~aw_done;
        wvalid    = active & ~w_done;
        aw_hs     = awvalid & awready;
        w_hs      = wvalid & wready;
        both_done = active & (aw_done | aw_hs) & (w_done | w_hs);
    end

    // Done flags are cleared whenever the bridge is not in the write-issue
    // state, which leaves them clean for the next store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (!active) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

endmodule

// File: rtl/data_axi_bridge.sv
// ---------------------------------------------------------------------------
// data_axi_bridge
// Turns one formatted SRAM-like data request into one single-beat AXI
// transaction, stalling the pipeline until it finishes.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/wen/addr/wdata request from EX (wen==0 means load)
//   req_size                 load size (0 byte, 1 half, 2 word)
//   stall                    freeze upstream stages
//   rdata, rdata_ok          raw load word and its one-cycle valid pulse
//   ar*/r*/aw*/w*/b*         AXI master channels
// ---------------------------------------------------------------------------
module data_axi_bridge
    import data_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [3:0]        req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_ok,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata_axi,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    bridge_state_t     state;
    bridge_state_t     state_next;
    logic [ADDR_W-1:0] lat_addr;
    logic [3:0]        lat_wen;
    logic [DATA_W-1:0] lat_wdata;
    logic [1:0]        lat_size;
    logic              wr_both_done;
    logic              unused_inputs;

    // Response IDs, response codes and rlast carry nothing this bridge acts on.
    assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

    // State register plus the request latch. Fields are captured only when
    // IDLE accepts a request, so upstream may change freely while stalled.
    // Load data is captured on the read handshake and held until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_wen   <= '0;
            lat_wdata <= '0;
            lat_size  <= '0;
            rdata     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                lat_addr  <= req_addr;
                lat_wen   <= req_wen;
                lat_wdata <= req_wdata;
                lat_size  <= req_size;
            end
            if (state == RD_D && rvalid) begin
                rdata <= rdata_axi;
            end
        end
    end

    axi_wr_chan u_wr_chan (
        .clk       (clk),
        .rst       (rst),
        .active    (state == WR_AW),
        .awready   (awready),
        .wready    (wready),
        .awvalid   (awvalid),
        .wvalid    (wvalid),
        .both_done (wr_both_done)
    );

    // Static channel fields come straight from the latched request. Word-size
    // stores are issued word-aligned and rely on wstrb to pick the lanes.
    always_comb begin
        arid    = AXI_ID;
        araddr  = lat_addr;
        arlen   = 8'd0;
        arsize  = {1'b0, lat_size};
        arburst = AXI_BURST_INCR;
        awid    = AXI_ID;
        awlen   = 8'd0;
        awsize  = axi_size_from_wen(lat_wen);
        awburst = AXI_BURST_INCR;
        awaddr  = (awsize == AXI_SIZE_W) ? {lat_addr[ADDR_W-1:2], 2'b00} : lat_addr;
        wid     = AXI_ID;
        wdata   = lat_wdata;
        wstrb   = lat_wen;
        wlast   = 1'b1;
    end

    // Next-state and handshake outputs. DONE is a single cycle in which the
    // pipeline advances; it never accepts a request, so a back-to-back
    // request is picked up by IDLE on the following cycle.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        bready     = 1'b0;
        rdata_ok   = 1'b0;
        case (state)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    state_next = (req_wen == 4'b0000) ? RD_A : WR_AW;
                end
            end
            RD_A: begin
                stall   = 1'b1;
                arvalid = 1'b1;
                if (arready) state_next = RD_D;
            end
            RD_D: begin
                stall  = 1'b1;
                rready = 1'b1;
                if (rvalid) state_next = DONE;
            end
            WR_AW: begin
                stall = 1'b1;
                if (wr_both_done) state_next = WR_B;
            end
            WR_B: begin
                stall  = 1'b1;
                bready = 1'b1;
                if (bvalid) state_next = DONE;
            end
            DONE: begin
                rdata_ok   = (lat_wen == 4'b0000);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
